// File: rtl/addsub_pkg.sv
// ----------------------------------------------------------------------------
// addsub_pkg
// Shared definitions for the pipelined add/subtract unit:
//   - bit positions inside the 3-bit mode vector {op_sub, op_unsigned, op_sat}
//   - saturation limit helpers (signed max/min for a given width)
//   - per-operation status flag struct carried down the pipeline
// ----------------------------------------------------------------------------
package addsub_pkg;

    localparam int MODE_W   = 3;
    localparam int MODE_SUB = 2;
    localparam int MODE_UNS = 1;
    localparam int MODE_SAT = 0;

    // Widest operand the helpers below must cover.
    localparam int MAX_WIDTH = 64;

    // Largest two's-complement value of the given width: 0111..1
    function automatic logic [MAX_WIDTH-1:0] sat_max(input int width);
        return (MAX_WIDTH'(1) << (width - 1)) - MAX_WIDTH'(1);
    endfunction

    // Most negative two's-complement value of the given width: 1000..0
    function automatic logic [MAX_WIDTH-1:0] sat_min(input int width);
        return MAX_WIDTH'(1) << (width - 1);
    endfunction

    // Status that travels with each result.
    typedef struct packed {
        logic overflow;
        logic carry_out;
        logic zero;
    } addsub_flags_t;

endpackage

// File: rtl/addsub_ovf_core.sv
// ----------------------------------------------------------------------------
// addsub_ovf_core
// Combinational add/subtract with signed/unsigned overflow detection and
// optional saturation. One operation per evaluation, no state.
// Ports:
//   operand_a, operand_b : WIDTH-bit operands
//   mode                 : {op_sub, op_unsigned, op_sat} (see addsub_pkg)
//   result               : wrapped or saturated result
//   flags                : raw overflow, raw adder carry, zero (post-saturation)
// ----------------------------------------------------------------------------
module addsub_ovf_core
    import addsub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int SAT_EN = 1
) (
    input  logic [WIDTH-1:0]  operand_a,
    input  logic [WIDTH-1:0]  operand_b,
    input  logic [MODE_W-1:0] mode,
    output logic [WIDTH-1:0]  result,
    output addsub_flags_t     flags
);

    localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min(WIDTH));

    logic             is_sub;
    logic             is_uns;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             ovf;
    logic             sat_req;

    always_comb begin
        is_sub = mode[MODE_SUB];
        is_uns = mode[MODE_UNS];

        // Subtraction is a + ~b + 1, so the carry-in is the subtract flag.
        b_eff        = is_sub ? ~operand_b : operand_b;
        {carry, sum} = {1'b0, operand_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};

        if (is_uns) begin
            // Unsigned subtract overflows when the adder does NOT carry (borrow).
            ovf = is_sub ? ~carry : carry;
        end else begin
            // Testing against b_eff rather than b also catches a - MIN.
            ovf = (operand_a[WIDTH-1] == b_eff[WIDTH-1]) &&
                  (sum[WIDTH-1] != operand_a[WIDTH-1]);
        end

        sat_req = (SAT_EN != 0) && mode[MODE_SAT] && ovf;

        result = sum;
        if (sat_req) begin
            if (is_uns) begin
                result = is_sub ? '0 : '1;
            end else begin
                // Signed overflow always goes in the direction of a's sign.
                result = operand_a[WIDTH-1] ? SAT_MIN : SAT_MAX;
            end
        end

        flags.overflow  = ovf;
        flags.carry_out = carry;
        flags.zero      = (result == '0);
    end

endmodule

// File: rtl/addsub_ovf_pipe.sv
// ----------------------------------------------------------------------------
// addsub_ovf_pipe
// Pipelined add/subtract unit with valid/ready handshake and sticky overflow.
// Stage 1 computes everything via addsub_ovf_core; further stages only delay.
// A stall at the output freezes every stage, so bubbles are kept in place.
// Ports:
//   clock, reset_n           : rising-edge clock, async active-low reset
//   in_valid / in_ready      : input handshake
//   operand_a, operand_b     : operands (sampled on accept)
//   op_sub, op_unsigned,
//   op_sat                   : operation mode (sampled on accept)
//   out_valid / out_ready    : output handshake
//   result, overflow,
//   carry_out, zero          : result and flags of the head operation
//   clear_sticky, sticky_ovf : sticky overflow status and its clear
// ----------------------------------------------------------------------------
module addsub_ovf_pipe
    import addsub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 1,
    parameter int SAT_EN = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             op_sub,
    input  logic             op_unsigned,
    input  logic             op_sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             carry_out,
    output logic             zero,
    input  logic             clear_sticky,
    output logic             sticky_ovf
);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        addsub_flags_t    flags;
    } payload_t;

    logic [MODE_W-1:0] mode_bits;
    payload_t          core_out;
    logic              stall;
    logic              head_valid;
    payload_t          head_data;
    logic              sticky_reg;
    logic              sticky_next;

    always_comb begin
        mode_bits           = '0;
        mode_bits[MODE_SUB] = op_sub;
        mode_bits[MODE_UNS] = op_unsigned;
        mode_bits[MODE_SAT] = op_sat;
    end

    addsub_ovf_core #(
        .WIDTH  (WIDTH),
        .SAT_EN (SAT_EN)
    ) u_core (
        .operand_a (operand_a),
        .operand_b (operand_b),
        .mode      (mode_bits),
        .result    (core_out.result),
        .flags     (core_out.flags)
    );

    assign stall    = head_valid && !out_ready;
    assign in_ready = !stall;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            logic     valid_reg;
            payload_t data_reg;
            logic     valid_in;
            payload_t data_in;

            if (gi == 0) begin : g_first
                // in_ready is 1 whenever this stage may load, so in_valid is the accept.
                assign valid_in = in_valid;
                assign data_in  = core_out;
            end else begin : g_delay
                assign valid_in = g_stage[gi-1].valid_reg;
                assign data_in  = g_stage[gi-1].data_reg;
            end

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    valid_reg <= 1'b0;
                    data_reg  <= '0;
                end else if (!stall) begin
                    valid_reg <= valid_in;
                    // Bubbles leave the payload untouched; only valid moves.
                    if (valid_in) begin
                        data_reg <= data_in;
                    end
                end
            end
        end
    endgenerate

    assign head_valid = g_stage[STAGES-1].valid_reg;
    assign head_data  = g_stage[STAGES-1].data_reg;

    assign out_valid = head_valid;
    assign result    = head_data.result;
    assign overflow  = head_data.flags.overflow;
    assign carry_out = head_data.flags.carry_out;
    assign zero      = head_data.flags.zero;

    // A new overflow event takes priority over a clear on the same edge.
    always_comb begin
        sticky_next = sticky_reg;
        if (head_valid && out_ready && head_data.flags.overflow) begin
            sticky_next = 1'b1;
        end else if (clear_sticky) begin
            sticky_next = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sticky_reg <= 1'b0;
        end else begin
            sticky_reg <= sticky_next;
        end
    end

    assign sticky_ovf = sticky_reg;

endmodule

// File: tb/tb_addsub_ovf_pipe.sv
// ----------------------------------------------------------------------------
// tb_addsub_ovf_pipe
// Directed corner cases plus randomized traffic for addsub_ovf_pipe
// (WIDTH=32, STAGES=2, SAT_EN=1). Expected values come from an
// arithmetic reference model and an in-order scoreboard queue.
// ----------------------------------------------------------------------------
module tb_addsub_ovf_pipe;

    localparam int WIDTH  = 32;
    localparam int STAGES = 2;
    localparam longint UMAX = 64'h0000_0000_FFFF_FFFF;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             op_sub;
    logic             op_unsigned;
    logic             op_sat;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             overflow;
    logic             carry_out;
    logic             zero;
    logic             clear_sticky;
    logic             sticky_ovf;

    always #5 clock = ~clock;

    addsub_ovf_pipe #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES),
        .SAT_EN (1)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .op_sub       (op_sub),
        .op_unsigned  (op_unsigned),
        .op_sat       (op_sat),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .overflow     (overflow),
        .carry_out    (carry_out),
        .zero         (zero),
        .clear_sticky (clear_sticky),
        .sticky_ovf   (sticky_ovf)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic        uns;
        logic        sat;
    } op_t;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        cy;
        logic        z;
        int          acc_cyc;
        bit          lat;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   cyc          = 0;
    logic exp_sticky   = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic op_t mk(input logic [31:0] a, input logic [31:0] b,
                               input logic sub, input logic uns, input logic sat);
        op_t op;
        op.a = a; op.b = b; op.sub = sub; op.uns = uns; op.sat = sat;
        return op;
    endfunction

    // Reference: exact arithmetic in 64 bits, then range test and clamp.
    function automatic exp_t model(input op_t op);
        exp_t   e;
        longint t;
        longint lo;
        longint hi;
        if (op.uns) begin
            t  = op.sub ? longint'(op.a) - longint'(op.b) : longint'(op.a) + longint'(op.b);
            lo = 0;
            hi = UMAX;
        end else begin
            t  = op.sub ? longint'($signed(op.a)) - longint'($signed(op.b))
                        : longint'($signed(op.a)) + longint'($signed(op.b));
            lo = -(longint'(1) << 31);
            hi = (longint'(1) << 31) - 1;
        end
        e.ovf = (t > hi) || (t < lo);
        if (e.ovf && op.sat) t = (t > hi) ? hi : lo;
        e.res = t[31:0];
        // Adder carry: no-borrow for subtract, 2^32 crossing for add.
        e.cy  = op.sub ? (op.a >= op.b) : ((longint'(op.a) + longint'(op.b)) > UMAX);
        e.z   = (e.res == 32'h0);
        e.acc_cyc = 0;
        e.lat     = 1'b0;
        return e;
    endfunction

    // Output monitor / scoreboard and sticky model.
    always @(negedge clock) begin
        exp_t e;
        logic xfer;
        logic set_ev;
        cyc++;
        if (!reset_n) begin
            exp_q.delete();
            exp_sticky = 1'b0;
        end
        check("sticky", sticky_ovf, exp_sticky);
        xfer   = out_valid && out_ready;
        set_ev = 1'b0;
        if (xfer) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", out_valid, 0);
            end else begin
                e = exp_q.pop_front();
                check("result", {result, overflow, carry_out, zero}, {e.res, e.ovf, e.cy, e.z});
                if (e.lat) check("latency", cyc - e.acc_cyc, STAGES);
                set_ev = e.ovf;
                $display("[TB] out res=0x%08h ovf=%0b cy=%0b z=%0b", result, overflow, carry_out, zero);
            end
        end
        if (set_ev) exp_sticky = 1'b1;
        else if (clear_sticky) exp_sticky = 1'b0;
    end

    // One clock of stimulus: drive at posedge+1, sample ready before the edge.
    task automatic step(input bit v, input op_t op, input bit ordy, input bit clr,
                        input bit lat, output bit acc);
        exp_t e;
        in_valid     = v;
        operand_a    = op.a;
        operand_b    = op.b;
        op_sub       = op.sub;
        op_unsigned  = op.uns;
        op_sat       = op.sat;
        out_ready    = ordy;
        clear_sticky = clr;
        @(negedge clock);
        acc = v && in_ready;
        @(posedge clock);
        if (acc) begin
            e = model(op);
            e.acc_cyc = cyc;
            e.lat     = lat;
            exp_q.push_back(e);
        end
        #1;
        in_valid     = 1'b0;
        clear_sticky = 1'b0;
    endtask

    task automatic run_one(input string tag, input op_t op, input logic [31:0] r,
                           input logic o, input logic c, input logic z, input bit clr_x);
        bit acc;
        bit seen = 1'b0;
        step(1'b1, op, 1'b1, 1'b0, 1'b1, acc);
        check({tag, "_acc"}, acc, 1);
        for (int k = 0; k < 6 && !seen; k++) begin
            step(1'b0, op, 1'b1, 1'b0, 1'b0, acc);
            if (out_valid) begin
                seen = 1'b1;
                check(tag, {result, overflow, carry_out, zero}, {r, o, c, z});
                step(1'b0, op, 1'b1, clr_x, 1'b0, acc);
            end
        end
        if (!seen) check({tag, "_timeout"}, seen, 1);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit  acc;
        op_t idle;
        op_t a_op, b_op, c_op;
        idle = mk(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        reset_n = 1'b0; in_valid = 1'b0; operand_a = '0; operand_b = '0;
        op_sub = 1'b0; op_unsigned = 1'b0; op_sat = 1'b0;
        out_ready = 1'b1; clear_sticky = 1'b0;
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_result", result, 0);
        check("rst_sticky", sticky_ovf, 0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;

        // Directed corner cases
        run_one("sadd_wrap", mk(32'h7FFFFFFF, 32'h1, 0, 0, 0), 32'h80000000, 1, 0, 0, 0);
        check("sticky_set", sticky_ovf, 1);
        run_one("sadd_sat", mk(32'h7FFFFFFF, 32'h1, 0, 0, 1), 32'h7FFFFFFF, 1, 0, 0, 1);
        check("sticky_set_wins", sticky_ovf, 1);
        step(1'b0, idle, 1'b1, 1'b1, 1'b0, acc);
        check("sticky_clear", sticky_ovf, 0);
        run_one("ssub_wrap", mk(32'h0, 32'h80000000, 1, 0, 0), 32'h80000000, 1, 0, 0, 0);
        run_one("ssub_sat", mk(32'h0, 32'h80000000, 1, 0, 1), 32'h7FFFFFFF, 1, 0, 0, 0);
        run_one("ssub_min_sat", mk(32'h80000000, 32'h1, 1, 0, 1), 32'h80000000, 1, 1, 0, 0);
        run_one("usub_sat", mk(32'd3, 32'd5, 1, 1, 1), 32'h0, 1, 0, 1, 0);
        run_one("usub_wrap", mk(32'd3, 32'd5, 1, 1, 0), 32'hFFFFFFFE, 1, 0, 0, 0);
        run_one("uadd_sat", mk(32'hFFFFFFFF, 32'h1, 0, 1, 1), 32'hFFFFFFFF, 1, 1, 0, 0);
        run_one("sadd_nov", mk(32'd5, 32'hFFFFFFFD, 0, 0, 1), 32'd2, 0, 1, 0, 0);
        run_one("usub_zero", mk(32'd7, 32'd7, 1, 1, 0), 32'h0, 0, 1, 1, 0);

        // Stalled overflow must not set sticky until it transfers
        step(1'b0, idle, 1'b1, 1'b1, 1'b0, acc);
        step(1'b1, mk(32'h7FFFFFFF, 32'h1, 0, 0, 0), 1'b0, 1'b0, 1'b0, acc);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, idle, 1'b0, 1'b0, 1'b0, acc);
            check("stall_sticky", sticky_ovf, 0);
        end
        check("stall_valid", out_valid, 1);
        step(1'b0, idle, 1'b1, 1'b0, 1'b0, acc);
        check("stall_sticky_xfer", sticky_ovf, 1);

        // Back-pressure: A, B issued, C held off for 3 stalled cycles
        a_op = mk(32'd11, 32'd22, 0, 1, 0);
        b_op = mk(32'd100, 32'd1, 1, 0, 0);
        c_op = mk(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1, 1);
        step(1'b1, a_op, 1'b0, 1'b0, 1'b0, acc);
        check("bp_acc_a", acc, 1);
        step(1'b1, b_op, 1'b0, 1'b0, 1'b0, acc);
        check("bp_acc_b", acc, 1);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, mk($urandom, $urandom, 1, 0, 1), 1'b0, 1'b0, 1'b0, acc);
            check("bp_in_ready", acc, 0);
            check("bp_hold_a", result, 32'd33);
        end
        step(1'b1, c_op, 1'b1, 1'b0, 1'b0, acc);
        check("bp_acc_c", acc, 1);
        repeat (4) step(1'b0, idle, 1'b1, 1'b0, 1'b0, acc);
        check("bp_drain", exp_q.size(), 0);

        // Reset with two operations in flight
        run_one("pre_rst", mk(32'h80000000, 32'h80000000, 0, 0, 0), 32'h0, 1, 1, 1, 0);
        step(1'b1, mk(32'd1, 32'd2, 0, 0, 0), 1'b1, 1'b0, 1'b0, acc);
        step(1'b1, mk(32'd3, 32'd4, 0, 0, 0), 1'b1, 1'b0, 1'b0, acc);
        check("pre_rst_valid", out_valid, 1);
        #1 reset_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_sticky", sticky_ovf, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_result", result, 0);
        @(posedge clock);
        repeat (2) step(1'b0, idle, 1'b1, 1'b0, 1'b0, acc);
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step(1'b0, idle, 1'b1, 1'b0, 1'b0, acc);
            check("post_rst_no_out", out_valid, 0);
        end
        check("post_rst_in_ready", in_ready, 1);

        // Randomized traffic with random back-pressure and clears
        for (int i = 0; i < 1500; i++) begin
            op_t op;
            op = mk(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
            step(($urandom_range(0, 3) != 0), op, ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 15) == 0), 1'b0, acc);
        end
        repeat (8) step(1'b0, idle, 1'b1, 1'b0, 1'b0, acc);
        check("final_drain", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
